alu_issue_ctrl: RTL and testbench

// - Initiator side of the ALU interface in the RV32 datapath.
// - Accepts one instruction word plus rs1/rs2 values over a valid/ready handshake.
// - Decodes it to an ALU op code and drives the ALU op/operand inputs, holding them stable for LAT cycles.
// - Captures the ALU result and returns it over a second valid/ready handshake.

---
 rtl/alu_issue_ctrl_if.sv | 30 +++
 rtl/alu_issue_ctrl.sv | 153 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - request, result and ALU-side signals of the ALU issue controller
interface alu_issue_ctrl_if #(
  parameter int N = 31
);
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [N:0]  rs1_val;
  logic [N:0]  rs2_val;
  logic [3:0]  alu_op;
  logic [N:0]  alu_a;
  logic [N:0]  alu_b;
  logic [N:0]  alu_out;
  logic        res_valid;
  logic        res_ready;
  logic [N:0]  result;
  logic        illegal;

  // master: the environment issuing requests and hosting the ALU
  modport master (
    output in_valid, instr, rs1_val, rs2_val, alu_out, res_ready,
    input  in_ready, alu_op, alu_a, alu_b, res_valid, result, illegal
  );

  // slave: the issue controller itself
  modport slave (
    input  in_valid, instr, rs1_val, rs2_val, alu_out, res_ready,
    output in_ready, alu_op, alu_a, alu_b, res_valid, result, illegal
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - decodes one RV32 ALU instruction, drives the ALU for LAT cycles, returns its result
module alu_issue_ctrl #(
  parameter int N   = 31,
  parameter int LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  alu_issue_ctrl_if.slave    bus,
  output logic               busy
);
  localparam int W  = N + 1;
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SRL = 4'd1;
  localparam logic [3:0] OP_OR  = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_SLL = 4'd4;

  typedef enum logic [1:0] {IDLE, DECODE, WAIT, DONE} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [31:0]    instr_q;
  logic [W-1:0]   rs1_q;
  logic [W-1:0]   rs2_q;

  logic [6:0]     opcode;
  logic [2:0]     funct3;
  logic [6:0]     funct7;
  logic           f3_ok;
  logic           is_shift;
  logic [3:0]     f3_op;
  logic           dec_legal;
  logic [3:0]     dec_op;
  logic [W-1:0]   dec_a;
  logic [W-1:0]   dec_b;
  logic           unused_rd;

  assign opcode    = instr_q[6:0];
  assign funct3    = instr_q[14:12];
  assign funct7    = instr_q[31:25];
  assign unused_rd = ^instr_q[11:7];

  // funct3 selects the operation identically for R-type and I-type
  always_comb begin
    f3_ok    = 1'b1;
    is_shift = 1'b0;
    f3_op    = OP_ADD;
    case (funct3)
      3'b000: f3_op = OP_ADD;
      3'b101: begin f3_op = OP_SRL; is_shift = 1'b1; end
      3'b110: f3_op = OP_OR;
      3'b111: f3_op = OP_AND;
      3'b001: begin f3_op = OP_SLL; is_shift = 1'b1; end
      default: f3_ok = 1'b0;
    endcase
  end

  always_comb begin
    dec_legal = 1'b0;
    dec_op    = f3_op;
    dec_a     = rs1_q;
    dec_b     = rs2_q;
    case (opcode)
      OPC_R: begin
        dec_legal = f3_ok && (funct7 == 7'd0);
        if (is_shift) dec_b = W'(rs2_q[4:0]);
      end
      OPC_I: begin
        dec_legal = f3_ok && (!is_shift || (funct7 == 7'd0));
        dec_b     = is_shift ? W'(instr_q[24:20]) : W'($signed(instr_q[31:20]));
      end
      // LUI reuses the shifter: upper immediate shifted left by 12
      OPC_LUI: begin
        dec_legal = 1'b1;
        dec_op    = OP_SLL;
        dec_a     = W'(instr_q[31:12]);
        dec_b     = W'(12);
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      instr_q       <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      busy          <= 1'b0;
      bus.in_ready  <= 1'b1;
      bus.res_valid <= 1'b0;
      bus.result    <= '0;
      bus.illegal   <= 1'b0;
      bus.alu_op    <= '0;
      bus.alu_a     <= '0;
      bus.alu_b     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            instr_q      <= bus.instr;
            rs1_q        <= bus.rs1_val;
            rs2_q        <= bus.rs2_val;
            bus.in_ready <= 1'b0;
            busy         <= 1'b1;
            state        <= DECODE;
          end
        end
        DECODE: begin
          cnt <= CW'(LAT - 1);
          if (dec_legal) begin
            bus.alu_op <= dec_op;
            bus.alu_a  <= dec_a;
            bus.alu_b  <= dec_b;
            state      <= WAIT;
          end else begin
            bus.result  <= '0;
            bus.illegal <= 1'b1;
            state       <= DONE;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            bus.result  <= bus.alu_out;
            bus.illegal <= 1'b0;
            state       <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          // res_valid is raised on the first DONE cycle, then held until taken
          if (!bus.res_valid) begin
            bus.res_valid <= 1'b1;
          end else if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - randomized and directed bench for alu_issue_ctrl against a behavioural model
module tb_alu_issue_ctrl;
  localparam int N   = 31;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   vectors     = 0;
  int   miscompares = 0;

  // model of the ALU inputs the controller should currently be holding
  logic [3:0]  m_op = '0;
  logic [31:0] m_a  = '0;
  logic [31:0] m_b  = '0;

  alu_issue_ctrl_if #(.N(N)) bus ();

  alu_issue_ctrl #(.N(N), .LAT(LAT)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a >> (b % 32);
      4'd2:    return a | b;
      4'd3:    return a & b;
      4'd4:    return a << (b % 32);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign bus.alu_out = ref_alu(bus.alu_op, bus.alu_a, bus.alu_b);

  function automatic void ref_decode(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                                     output bit ok, output logic [3:0] op,
                                     output logic [31:0] a, output logic [31:0] b);
    int  code;
    bit  shift;
    case (ins[14:12])
      3'd0: code = 0;
      3'd5: code = 1;
      3'd6: code = 2;
      3'd7: code = 3;
      3'd1: code = 4;
      default: code = -1;
    endcase
    shift = (code == 1) || (code == 4);
    ok = 0; op = 4'(code); a = r1; b = r2;
    if (ins[6:0] == 7'h33 && code >= 0 && ins[31:25] == 0) begin
      ok = 1;
      if (shift) b = r2 % 32;
    end else if (ins[6:0] == 7'h13 && code >= 0) begin
      ok = !shift || ins[31:25] == 0;
      b  = shift ? 32'(ins[24:20]) : 32'($signed(ins) >>> 20);
    end else if (ins[6:0] == 7'h37) begin
      ok = 1; op = 4; a = ins >> 12; b = 12;
    end
  endfunction

  task automatic model_req(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                           output int elat, output logic [31:0] eres, output logic eill);
    bit ok; logic [3:0] op; logic [31:0] a, b;
    ref_decode(ins, r1, r2, ok, op, a, b);
    if (ok) begin
      m_op = op; m_a = a; m_b = b;
      elat = LAT + 2; eres = ref_alu(op, a, b); eill = 1'b0;
    end else begin
      elat = 2; eres = '0; eill = 1'b1;
    end
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2, input int hold,
                       output int lat, output logic [31:0] res, output logic ill, output logic [3:0] op,
                       output logic [31:0] a, output logic [31:0] b, output logic post_rdy, output logic post_vld);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.instr = ins; bus.rs1_val = r1; bus.rs2_val = r2;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.instr = $urandom; bus.rs1_val = $urandom; bus.rs2_val = $urandom;
    lat = -1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (bus.res_valid) lat = k;
    end
    res = bus.result; ill = bus.illegal; op = bus.alu_op; a = bus.alu_a; b = bus.alu_b;
    repeat (hold) begin @(posedge clk); #1; end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    post_rdy = bus.in_ready; post_vld = bus.res_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL reset_res_valid got %b want 0", bus.res_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if ({bus.alu_op, bus.alu_a, bus.alu_b} !== '0) begin
      miscompares++; $display("FAIL reset_alu got op=%0d a=%h b=%h want 0", bus.alu_op, bus.alu_a, bus.alu_b); end
    vectors++; if ({bus.result, bus.illegal} !== '0) begin
      miscompares++; $display("FAIL reset_result got %h/%b want 0/0", bus.result, bus.illegal); end
  endtask

  task automatic test_add();
    int lat, el; logic [31:0] res, er, a, b; logic ill, ei, pr, pv; logic [3:0] op;
    model_req(32'h00208033, 32'd5, 32'd7, el, er, ei);
    issue(32'h00208033, 32'd5, 32'd7, 0, lat, res, ill, op, a, b, pr, pv);
    vectors++; if (lat !== LAT + 2) begin miscompares++; $display("FAIL add_latency got %0d want %0d", lat, LAT + 2); end
    vectors++; if (res !== 32'd12 || ill !== 1'b0) begin miscompares++; $display("FAIL add_result got %0d/%b want 12/0", res, ill); end
    vectors++; if ({op, a, b} !== {4'd0, 32'd5, 32'd7}) begin miscompares++; $display("FAIL add_alu got op=%0d a=%0d b=%0d want 0/5/7", op, a, b); end
    vectors++; if ({pr, pv, busy} !== 3'b100) begin miscompares++; $display("FAIL add_release got rdy=%b vld=%b busy=%b want 1/0/0", pr, pv, busy); end
  endtask

  task automatic test_lui();
    int lat, el; logic [31:0] res, er, a, b; logic ill, ei, pr, pv; logic [3:0] op;
    model_req(32'h123450B7, 32'h0, 32'h0, el, er, ei);
    issue(32'h123450B7, $urandom, $urandom, 1, lat, res, ill, op, a, b, pr, pv);
    vectors++; if ({op, a, b} !== {4'd4, 32'h12345, 32'd12}) begin
      miscompares++; $display("FAIL lui_alu got op=%0d a=%h b=%0d want 4/12345/12", op, a, b); end
    vectors++; if (res !== 32'h12345000 || ill !== 1'b0) begin miscompares++; $display("FAIL lui_result got %h/%b want 12345000/0", res, ill); end
    vectors++; if (lat !== LAT + 2) begin miscompares++; $display("FAIL lui_latency got %0d want %0d", lat, LAT + 2); end
  endtask

  task automatic test_srli_srai();
    int lat, el; logic [31:0] res, er, a, b; logic ill, ei, pr, pv; logic [3:0] op;
    model_req(32'h0040D093, 32'hF0, 32'h0, el, er, ei);
    issue(32'h0040D093, 32'hF0, $urandom, 0, lat, res, ill, op, a, b, pr, pv);
    vectors++; if ({op, b} !== {4'd1, 32'd4}) begin miscompares++; $display("FAIL srli_alu got op=%0d b=%0d want 1/4", op, b); end
    vectors++; if (res !== 32'h0F || ill !== 1'b0) begin miscompares++; $display("FAIL srli_result got %h/%b want f/0", res, ill); end
    model_req(32'h4040D093, 32'h55, 32'h0, el, er, ei);
    issue(32'h4040D093, 32'h55, 32'h66, 0, lat, res, ill, op, a, b, pr, pv);
    vectors++; if (res !== 32'h0 || ill !== 1'b1) begin miscompares++; $display("FAIL srai_illegal got %h/%b want 0/1", res, ill); end
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL srai_latency got %0d want 2", lat); end
    vectors++; if ({op, a, b} !== {4'd1, 32'hF0, 32'd4}) begin
      miscompares++; $display("FAIL srai_alu_held got op=%0d a=%h b=%0d want 1/f0/4", op, a, b); end
    vectors++; if ({pr, pv} !== 2'b10) begin miscompares++; $display("FAIL srai_release got rdy=%b vld=%b want 1/0", pr, pv); end
  endtask

  task automatic test_backpressure();
    int lat, el; logic [31:0] er; logic ei;
    model_req(32'h00208033, 32'd100, 32'd23, el, er, ei);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.instr = 32'h00208033; bus.rs1_val = 32'd100; bus.rs2_val = 32'd23;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (bus.res_valid) lat = k;
    end
    vectors++; if (lat !== el) begin miscompares++; $display("FAIL bp_latency got %0d want %0d", lat, el); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.instr = 32'h123450B7;
      @(posedge clk); #1;
      vectors++; if ({bus.res_valid, bus.in_ready, bus.illegal, bus.result} !== {1'b1, 1'b0, ei, er}) begin
        miscompares++;
        $display("FAIL bp_hold cycle %0d got vld=%b rdy=%b ill=%b res=%0d want 1/0/0/%0d",
                 c, bus.res_valid, bus.in_ready, bus.illegal, bus.result, er);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.res_ready = 1'b1;
    @(posedge clk); #1 bus.res_ready = 1'b0;
    vectors++; if ({bus.in_ready, bus.res_valid, busy} !== 3'b100) begin
      miscompares++; $display("FAIL bp_release got rdy=%b vld=%b busy=%b want 1/0/0", bus.in_ready, bus.res_valid, busy); end
    repeat (2) @(posedge clk);
    #1;
    vectors++; if ({busy, bus.in_ready} !== 2'b01) begin
      miscompares++; $display("FAIL bp_ignored_req got busy=%b rdy=%b want 0/1", busy, bus.in_ready); end
  endtask

  task automatic test_random();
    int lat, el, kind; logic [31:0] res, er, a, b, ins, r1, r2; logic ill, ei, pr, pv; logic [3:0] op;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      r1 = $urandom; r2 = $urandom; ins = $urandom;
      case (kind)
        0: ins = {($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'd0, ins[24:7], 7'h33};
        1: ins = {($urandom_range(0, 3) == 0) ? ins[31:25] : 7'd0, ins[24:7], 7'h13};
        2: ins = {ins[31:7], 7'h37};
        default: ;
      endcase
      model_req(ins, r1, r2, el, er, ei);
      issue(ins, r1, r2, $urandom_range(0, 3), lat, res, ill, op, a, b, pr, pv);
      vectors++; if (lat !== el) begin miscompares++; $display("FAIL rand%0d_latency instr=%h got %0d want %0d", i, ins, lat, el); end
      vectors++; if (res !== er || ill !== ei) begin
        miscompares++; $display("FAIL rand%0d_result instr=%h got %h/%b want %h/%b", i, ins, res, ill, er, ei); end
      vectors++; if ({op, a, b} !== {m_op, m_a, m_b}) begin
        miscompares++; $display("FAIL rand%0d_alu instr=%h got %0d/%h/%h want %0d/%h/%h", i, ins, op, a, b, m_op, m_a, m_b); end
      vectors++; if ({pr, pv} !== 2'b10) begin miscompares++; $display("FAIL rand%0d_release got rdy=%b vld=%b want 1/0", i, pr, pv); end
    end
  endtask

  task automatic test_reset_mid_wait();
    int lat, el; logic [31:0] res, er, a, b; logic ill, ei, pr, pv, seen; logic [3:0] op;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.instr = 32'h00208033; bus.rs1_val = 32'd1; bus.rs2_val = 32'd2;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    @(posedge clk); #1;
    vectors++; if ({busy, bus.res_valid} !== 2'b10) begin miscompares++; $display("FAIL midrst_inflight got busy=%b vld=%b want 1/0", busy, bus.res_valid); end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    vectors++; if ({bus.in_ready, busy, bus.res_valid} !== 3'b100) begin
      miscompares++; $display("FAIL midrst_idle got rdy=%b busy=%b vld=%b want 1/0/0", bus.in_ready, busy, bus.res_valid); end
    seen = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (bus.res_valid) seen = 1'b1; end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL midrst_dropped got res_valid=%b want 0", seen); end
    model_req(32'h00208033, 32'd40, 32'd2, el, er, ei);
    issue(32'h00208033, 32'd40, 32'd2, 0, lat, res, ill, op, a, b, pr, pv);
    vectors++; if (lat !== el || res !== er) begin
      miscompares++; $display("FAIL midrst_next got lat=%0d res=%0d want %0d/%0d", lat, res, el, er); end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.res_ready = 1'b0;
    bus.instr = '0; bus.rs1_val = '0; bus.rs2_val = '0;
    test_reset();
    test_add();
    test_lui();
    test_srli_srai();
    test_backpressure();
    test_random();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
